// File: rtl/pr_feeder_pkg.sv
// Shared types and constants for the PR data feeder.
//   state_t       : session FSM states
//   IP_*          : PR IP status encodings seen on pr_ip_status
//   ERR_*         : bit positions inside csr_err
//   is_ip_fault() : true for the status codes that abort a session
package pr_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_DRAIN,
        ST_WAIT_DONE,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [2:0] IP_IDLE     = 3'd0;
    localparam logic [2:0] IP_ERROR    = 3'd1;
    localparam logic [2:0] IP_CRC_ERR  = 3'd2;
    localparam logic [2:0] IP_INCOMPAT = 3'd3;
    localparam logic [2:0] IP_BUSY     = 3'd4;
    localparam logic [2:0] IP_SUCCESS  = 3'd5;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_IP       = 1;
    localparam int ERR_PROTOCOL = 2;
    localparam int ERR_TIMEOUT  = 3;

    function automatic logic is_ip_fault(input logic [2:0] status);
        return (status == IP_ERROR) || (status == IP_CRC_ERR) || (status == IP_INCOMPAT);
    endfunction

endpackage

// File: rtl/pr_feeder_fifo.sv
// Show-ahead FIFO for 64-bit PR bitstream words.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous discard of all contents
//   wr_en/wr_data : push; accepted when not full, or when full with a pop in the same cycle
//   rd_en         : pop the head word (ignored when empty)
//   rd_data       : head word, valid whenever empty is low
//   full/empty/count : occupancy
// The head is read combinationally so a word is visible the cycle after it is written;
// at this depth the array maps to distributed RAM.
module pr_feeder_fifo
    import pr_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pr_data_feeder.sv
// PR data feeder: buffers 64-bit PG_PR_DATA words and streams them as 32-bit beats
// (low half first) to the FPGA PR controller, sequencing the start/done handshake.
//   clk, rst                    : clock, asynchronous active-high reset
//   csr_pr_reset                : level soft reset from PG_PR_CTRL; acked on csr_reset_ack
//   csr_start_req, csr_push_complete, csr_data_wr/csr_data : CSR pulses and payload
//   pr_start, pr_data, pr_valid, pr_ready, pr_ip_status    : PR IP interface
//   csr_pr_status, csr_fifo_full, csr_err, csr_word_cnt     : status back to the CSR block
// Optional macro PR_FEEDER_TIMEOUT_EN adds a session watchdog that raises csr_err[3].
module pr_data_feeder
    import pr_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int PR_DW       = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_pr_reset,
    input  logic             csr_start_req,
    input  logic             csr_push_complete,
    input  logic             csr_data_wr,
    input  logic [63:0]      csr_data,
    output logic             pr_start,
    output logic [PR_DW-1:0] pr_data,
    output logic             pr_valid,
    input  logic             pr_ready,
    input  logic [2:0]       pr_ip_status,
    output logic             csr_reset_ack,
    output logic             csr_pr_status,
    output logic             csr_fifo_full,
    output logic [3:0]       csr_err,
    output logic [31:0]      csr_word_cnt
);
    state_t                    state_reg;
    state_t                    state_next;
    logic                      pr_valid_reg;
    logic [PR_DW-1:0]          pr_data_reg;
    logic                      half_reg;       // 1: next beat to load is the high half of the head
    logic [3:0]                err_reg;
    logic [3:0]                err_set;
    logic [31:0]               word_cnt_reg;
    logic                      reset_ack_reg;

    logic [63:0]               fifo_rd_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic sess_active;
    logic streaming;
    logic timeout_hit;
    logic go_err;
    logic emit_en;
    logic load;
    logic pop;
    logic wr_ok;
    logic push;
    logic overflow;
    logic session_start;
    logic flush;

    assign sess_active = state_reg inside {ST_START, ST_STREAM, ST_DRAIN, ST_WAIT_DONE};
    assign streaming   = state_reg inside {ST_STREAM, ST_DRAIN};
    assign go_err      = sess_active && (is_ip_fault(pr_ip_status) || timeout_hit);

    // Output register refills whenever it is empty or its beat is being taken.
    assign emit_en  = streaming && !go_err && !csr_pr_reset;
    assign load     = emit_en && (!pr_valid_reg || pr_ready) && !fifo_empty;
    assign pop      = load && half_reg;

    assign wr_ok    = (state_reg == ST_STREAM) && csr_data_wr && !go_err && !csr_pr_reset;
    assign push     = wr_ok && (!fifo_full || pop);
    assign overflow = wr_ok && fifo_full && !pop;

    assign session_start = csr_start_req && (state_reg inside {ST_IDLE, ST_DONE, ST_ERR});
    assign flush         = csr_pr_reset || go_err || (state_reg inside {ST_DONE, ST_ERR});

`ifdef PR_FEEDER_TIMEOUT_EN
    logic        beat_xfer;
    logic [31:0] wdog_reg;

    assign beat_xfer   = pr_valid_reg && pr_ready;
    assign timeout_hit = sess_active && (wdog_reg == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_reg <= '0;
        end else if (csr_pr_reset || !sess_active || beat_xfer || (state_next != state_reg)) begin
            wdog_reg <= '0;
        end else begin
            wdog_reg <= wdog_reg + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        err_set               = '0;
        err_set[ERR_OVERFLOW] = overflow;
        err_set[ERR_IP]       = sess_active && is_ip_fault(pr_ip_status);
        err_set[ERR_PROTOCOL] = csr_data_wr && (state_reg inside {ST_IDLE, ST_DRAIN});
        err_set[ERR_TIMEOUT]  = timeout_hit;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: if (csr_start_req) state_next = ST_START;
            ST_START:     if (pr_ip_status == IP_BUSY) state_next = ST_STREAM;
            ST_STREAM:    if (csr_push_complete) state_next = ST_DRAIN;
            ST_DRAIN:     if ((fifo_count == '0) && !pr_valid_reg) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (pr_ip_status == IP_SUCCESS) state_next = ST_DONE;
            default:      state_next = ST_IDLE;
        endcase
        if (go_err) begin
            state_next = ST_ERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pr_valid_reg  <= 1'b0;
            pr_data_reg   <= '0;
            half_reg      <= 1'b0;
            err_reg       <= '0;
            word_cnt_reg  <= '0;
            reset_ack_reg <= 1'b0;
        end else if (csr_pr_reset) begin
            state_reg     <= ST_IDLE;
            pr_valid_reg  <= 1'b0;
            pr_data_reg   <= '0;
            half_reg      <= 1'b0;
            err_reg       <= '0;
            word_cnt_reg  <= '0;
            reset_ack_reg <= 1'b1;
        end else begin
            reset_ack_reg <= 1'b0;
            state_reg     <= state_next;

            if (session_start) begin
                err_reg      <= '0;
                word_cnt_reg <= '0;
            end else begin
                err_reg <= err_reg | err_set;
                if (push) begin
                    word_cnt_reg <= word_cnt_reg + 32'd1;
                end
            end

            if (load) begin
                pr_valid_reg <= 1'b1;
                pr_data_reg  <= half_reg ? fifo_rd_data[2*PR_DW-1:PR_DW] : fifo_rd_data[PR_DW-1:0];
                half_reg     <= ~half_reg;
            end else if (!emit_en) begin
                pr_valid_reg <= 1'b0;
                half_reg     <= 1'b0;
            end else if (pr_ready) begin
                pr_valid_reg <= 1'b0;
            end
        end
    end

    pr_feeder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (push),
        .wr_data (csr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pr_start      = state_reg inside {ST_START, ST_STREAM, ST_DRAIN};
    assign pr_data       = pr_data_reg;
    assign pr_valid      = pr_valid_reg;
    assign csr_reset_ack = reset_ack_reg;
    assign csr_pr_status = sess_active;
    assign csr_fifo_full = fifo_full;
    assign csr_err       = err_reg;
    assign csr_word_cnt  = word_cnt_reg;

endmodule

// File: tb/tb_pr_data_feeder.sv
module tb_pr_data_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_pr_reset;
    logic        csr_start_req;
    logic        csr_push_complete;
    logic        csr_data_wr;
    logic [63:0] csr_data;
    logic        pr_start;
    logic [31:0] pr_data;
    logic        pr_valid;
    logic        pr_ready;
    logic [2:0]  pr_ip_status;
    logic        csr_reset_ack;
    logic        csr_pr_status;
    logic        csr_fifo_full;
    logic [3:0]  csr_err;
    logic [31:0] csr_word_cnt;

    int          tests = 0;
    int          fails = 0;
    int          beat_cnt = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    pr_data_feeder #(
        .FIFO_DEPTH  (16),
        .PR_DW       (32),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .csr_pr_reset      (csr_pr_reset),
        .csr_start_req     (csr_start_req),
        .csr_push_complete (csr_push_complete),
        .csr_data_wr       (csr_data_wr),
        .csr_data          (csr_data),
        .pr_start          (pr_start),
        .pr_data           (pr_data),
        .pr_valid          (pr_valid),
        .pr_ready          (pr_ready),
        .pr_ip_status      (pr_ip_status),
        .csr_reset_ack     (csr_reset_ack),
        .csr_pr_status     (csr_pr_status),
        .csr_fifo_full     (csr_fifo_full),
        .csr_err           (csr_err),
        .csr_word_cnt      (csr_word_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        csr_start_req = 1'b1;
        tick();
        csr_start_req = 1'b0;
    endtask

    task automatic push_complete();
        csr_push_complete = 1'b1;
        tick();
        csr_push_complete = 1'b0;
    endtask

    task automatic write_word(input logic [63:0] w, input bit expect_beats);
        if (expect_beats) begin
            sb.push_back(w[31:0]);
            sb.push_back(w[63:32]);
        end
        csr_data    = w;
        csr_data_wr = 1'b1;
        tick();
        csr_data_wr = 1'b0;
        $display("[TB] write 0x%016h", w);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (sb.size() != 0 || pr_valid); i++) begin
            tick();
        end
        check("drain_done", {63'd0, (sb.size() == 0) && !pr_valid}, 64'd1);
    endtask

    task automatic finish_session();
        tick();
        tick();
        check("wait_done_pr_start", pr_start, 0);
        check("wait_done_status", csr_pr_status, 1);
        pr_ip_status = 3'd5;
        tick();
        pr_ip_status = 3'd0;
        check("done_status", csr_pr_status, 0);
    endtask

    // Beat scoreboard: every handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst === 1'b0 && pr_valid === 1'b1 && pr_ready === 1'b1) begin
            beat_cnt++;
            $display("[TB] beat 0x%08h", pr_data);
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL beat_unexpected observed=0x%0h expected=none", pr_data);
            end
            if (sb.size() != 0) begin
                check("beat", pr_data, sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst = 1'b1; csr_pr_reset = 1'b0; csr_start_req = 1'b0; csr_push_complete = 1'b0;
        csr_data_wr = 1'b0; csr_data = '0; pr_ready = 1'b0; pr_ip_status = 3'd0;
        tick();
        tick();
        check("rst_pr_valid", pr_valid, 0);
        check("rst_pr_start", pr_start, 0);
        check("rst_status", csr_pr_status, 0);
        check("rst_err", csr_err, 0);
        check("rst_word_cnt", csr_word_cnt, 0);
        check("rst_fifo_full", csr_fifo_full, 0);
        check("rst_ack", csr_reset_ack, 0);
        rst = 1'b0;
        tick();

        // Data written while idle is a protocol error and is dropped.
        write_word(64'hDEAD_BEEF_0000_0001, 1'b0);
        check("idle_wr_err", csr_err, 4'b0100);
        check("idle_wr_cnt", csr_word_cnt, 0);
        tick();
        check("idle_wr_valid", pr_valid, 0);

        // Basic session: two words, four beats in low/high order.
        start_session();
        check("start_pr_start", pr_start, 1);
        check("start_status", csr_pr_status, 1);
        check("start_err_clr", csr_err, 0);
        pr_ip_status = 3'd4;
        tick();
        pr_ready = 1'b1;
        write_word(64'h1111_2222_3333_4444, 1'b1);
        check("lat_not_yet", pr_valid, 0);
        write_word(64'h5555_6666_7777_8888, 1'b1);
        check("lat_first_valid", pr_valid, 1);
        check("lat_first_data", pr_data, 32'h3333_4444);
        push_complete();
        wait_drain();
        finish_session();
        check("s1_word_cnt", csr_word_cnt, 2);
        check("s1_valid", pr_valid, 0);

        // Overflow: 17 writes with the IP stalled.
        pr_ready = 1'b0;
        start_session();
        pr_ip_status = 3'd4;
        tick();
        for (int i = 0; i < 17; i++) begin
            write_word({32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)}, i < 16);
            if (i == 14) check("ovf_not_full_15", csr_fifo_full, 0);
            if (i == 15) check("ovf_full_16", csr_fifo_full, 1);
        end
        check("ovf_err", csr_err, 4'b0001);
        check("ovf_word_cnt", csr_word_cnt, 16);
        base = beat_cnt;
        pr_ready = 1'b1;
        push_complete();
        wait_drain();
        check("ovf_beats", 64'(beat_cnt - base), 32);
        finish_session();

        // IP CRC error mid-stream aborts and flushes.
        pr_ready = 1'b0;
        start_session();
        check("s3_err_clr", csr_err, 0);
        check("s3_cnt_clr", csr_word_cnt, 0);
        pr_ip_status = 3'd4;
        tick();
        for (int i = 0; i < 3; i++) write_word(64'hC0C0_0000_0000_0000 + 64'(i), 1'b0);
        check("crc_pre_valid", pr_valid, 1);
        pr_ip_status = 3'd2;
        tick();
        check("crc_valid", pr_valid, 0);
        check("crc_err", csr_err, 4'b0010);
        check("crc_status", csr_pr_status, 0);
        check("crc_pr_start", pr_start, 0);
        pr_ip_status = 3'd0;
        tick();
        start_session();
        check("crc_restart_err_clr", csr_err, 0);
        pr_ip_status = 3'd4;
        tick();
        pr_ready = 1'b1;
        repeat (6) tick();
        check("crc_flushed", pr_valid, 0);
        push_complete();
        finish_session();

        // Soft reset with 5 words queued.
        pr_ready = 1'b0;
        start_session();
        pr_ip_status = 3'd4;
        tick();
        for (int i = 0; i < 5; i++) write_word(64'h5E5E_0000_0000_0000 + 64'(i), 1'b0);
        check("srst_pre_valid", pr_valid, 1);
        check("srst_pre_cnt", csr_word_cnt, 5);
        csr_pr_reset = 1'b1;
        tick();
        check("srst_ack", csr_reset_ack, 1);
        check("srst_valid", pr_valid, 0);
        check("srst_pr_start", pr_start, 0);
        check("srst_status", csr_pr_status, 0);
        check("srst_cnt", csr_word_cnt, 0);
        tick();
        check("srst_ack_held", csr_reset_ack, 1);
        csr_pr_reset = 1'b0;
        tick();
        check("srst_ack_clr", csr_reset_ack, 0);
        write_word(64'h0BAD_0000_0000_0000, 1'b0);
        check("srst_idle_err", csr_err, 4'b0100);
        start_session();
        tick();
        pr_ready = 1'b1;
        repeat (6) tick();
        check("srst_fifo_empty", pr_valid, 0);
        push_complete();
        finish_session();

`ifdef PR_FEEDER_TIMEOUT_EN
        pr_ip_status = 3'd0;
        start_session();
        repeat (99) tick();
        check("wdog_not_yet", csr_err[3], 0);
        check("wdog_active", csr_pr_status, 1);
        tick();
        check("wdog_err", csr_err[3], 1);
        check("wdog_state_err", csr_pr_status, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pr_data_feeder.md
Name: pr_data_feeder

Overview:
- Sits directly downstream of the port-gasket PR CSR block (PG_PR_CTRL/STATUS/DATA/ERROR).
- Accepts 64-bit PR bitstream words written to PG_PR_DATA and buffers them in a FIFO.
- Serialises the words into 32-bit beats toward the FPGA PR controller IP and sequences the start/complete/status handshake.
- Returns status and error summary bits for PG_PR_STATUS/PG_PR_ERROR.

Parameters:
- FIFO_DEPTH, 16, depth of the 64-bit word FIFO; power of 2, ≥4.
- PR_DW, 32, width of a data beat to the PR IP; fixed at half of 64.
- TIMEOUT_CYC, 65535, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- csr_pr_reset  in  1  PRReset bit from PG_PR_CTRL; level-sensitive soft reset.
- csr_start_req  in  1  one-cycle pulse, PRStartRequest written to 1.
- csr_push_complete  in  1  one-cycle pulse, PRDataPushComplete written to 1.
- csr_data_wr  in  1  one-cycle pulse, PG_PR_DATA write strobe.
- csr_data  in  64  PG_PR_DATA write payload.
- pr_start  out  1  start request to PR IP.
- pr_data  out  32  data beat to PR IP.
- pr_valid  out  1  pr_data valid.
- pr_ready  in  1  PR IP accepts a beat.
- pr_ip_status  in  3  PR IP status: 0 idle, 1 error, 2 CRC error, 3 incompatible, 4 busy, 5 success.
- csr_reset_ack  out  1  PRReset_ack.
- csr_pr_status  out  1  PRStatus bit: 1 while a PR session is active.
- csr_fifo_full  out  1  FIFO full; software must poll before writing.
- csr_err  out  4  sticky errors: [0] overflow, [1] IP error/CRC/incompatible, [2] protocol (data before start), [3] timeout.
- csr_word_cnt  out  32  64-bit words accepted this session.

Behaviour:
- Reset (rst or csr_pr_reset): all outputs 0, FIFO empty, FSM to IDLE. csr_reset_ack is 1 while csr_pr_reset is held, one cycle after it asserts.
- IDLE:
  - csr_start_req → START; clear csr_err and csr_word_cnt.
  - csr_data_wr in IDLE → drop word, set err[2].
- START: pr_start=1. Stay until pr_ip_status==4, then → STREAM. Status 1/2/3 → ERR.
- STREAM:
  - Accept csr_data_wr into the FIFO when not full; csr_word_cnt += 1, wraps at 2^32.
  - Write while full → drop word, set err[0], count unchanged.
  - Output side: the head word is split into two beats, low half [31:0] first, then [63:32]; pop after the high beat handshakes.
  - A beat transfers when pr_valid and pr_ready are both 1. pr_valid and pr_data hold stable until the transfer; no combinational path from pr_ready to pr_valid.
  - First beat is valid 1 cycle after the FIFO goes non-empty; sustains 1 beat per cycle under continuous pr_ready.
  - Simultaneous push and pop when full is allowed (pop frees the slot in the same cycle).
  - csr_push_complete → DRAIN.
- DRAIN: continue emitting beats; further writes set err[2] and are dropped. FIFO empty and no partial beat → WAIT_DONE.
- WAIT_DONE: pr_start=0.
  - pr_ip_status==5 → DONE.
  - pr_ip_status 1/2/3 → ERR (set err[1]).
- Any state: pr_ip_status 1/2/3 observed outside IDLE/DONE → ERR.
- DONE / ERR:
  - csr_pr_status=0; FIFO flushed; pr_valid=0.
  - Return to IDLE on the next csr_start_req, which then also starts a new session (IDLE handling in the same cycle).
- csr_pr_status=1 in START, STREAM, DRAIN, WAIT_DONE.
- csr_start_req outside IDLE/DONE/ERR is ignored.
- Reset mid-stream: FIFO contents discarded, pr_valid drops immediately (async).

Optional Feature:
- Macro PR_FEEDER_TIMEOUT_EN.
- When defined: a watchdog counter is cleared on any beat transfer or state change and increments while in START, STREAM, DRAIN or WAIT_DONE. On reaching TIMEOUT_CYC it sets err[3] and moves to ERR.
- When undefined: no counter, err[3] tied 0, TIMEOUT_CYC unused.

Decomposition:
- Package pr_feeder_pkg:
  - state enum (IDLE, START, STREAM, DRAIN, WAIT_DONE, DONE, ERR)
  - PR IP status encodings
  - csr_err bit-index constants
- One sub-module, pr_feeder_fifo: synchronous show-ahead FIFO, 64-bit wide, FIFO_DEPTH deep, with full/empty/count and a flush input.

Test Plan:
- start, IP status 4, write 0x1111_2222_3333_4444 then 0x5555_6666_7777_8888, push_complete, status 5 → beats 0x33334444, 0x11112222, 0x77778888, 0x55556666 in that order; word_cnt=2; DONE; csr_pr_status 1→0.
- pr_ready held low, 17 writes with FIFO_DEPTH=16 → fifo_full=1 after the 16th write; err[0]=1; word_cnt=16; after ready is released exactly 32 beats are emitted.
- csr_data_wr in IDLE → err[2]=1, no pr_valid, word_cnt=0.
- IP status 2 during STREAM → ERR, err[1]=1, pr_valid=0 next cycle, FIFO flushed; new start_req clears errors.
- csr_pr_reset asserted mid-stream with 5 words queued → csr_reset_ack=1, FIFO empty, pr_start=0, state IDLE.
- With PR_FEEDER_TIMEOUT_EN and TIMEOUT_CYC=100: START with status held at 0 → err[3]=1 after 100 cycles, state ERR.
